// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage. Drives the data-memory handshake,
// aligns store data onto byte lanes, extracts/extends load data, flags
// misaligned accesses and registers the MEM/WB pipeline outputs.
// Optional build macro: MEM_TIMEOUT_EN adds an 8-bit wait counter that
// abandons a stuck access and raises the sticky dmem_timeout flag.
//
// state  | meaning
// S_IDLE | no outstanding access; a new request may be issued
// S_WAIT | request issued, waiting for dmem_ack
module mem_access_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        memtoreg_in,
  input  logic        regwrite_in,
  input  logic [3:0]  memwrite_in,
  input  logic [31:0] ALUout_in,
  input  logic [31:0] rv2_in,
  input  logic [31:0] immgen_in,
  input  logic [1:0]  regin_in,
  input  logic [31:0] PC_plus4_in,
  input  logic [31:0] idata_in,
  output logic        dmem_req,
  output logic [3:0]  dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        regwrite_out,
  output logic [1:0]  regin_out,
  output logic        memtoreg_out,
  output logic [31:0] ALUout_out,
  output logic [31:0] ldata_out,
  output logic [31:0] immgen_out,
  output logic [31:0] PC_plus4_out,
  output logic [4:0]  rd_out,
  output logic        mem_stall,
`ifdef MEM_TIMEOUT_EN
  output logic        dmem_timeout,
`endif
  output logic        misalign_err
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      state, state_nxt;
  logic        access, misaligned, timeout_hit;
  logic [2:0]  funct3;
  logic [4:0]  shamt;
  logic [31:0] rdata_shift, load_data;
  logic        unused_idata;

  assign funct3       = idata_in[14:12];
  assign shamt        = {ALUout_in[1:0], 3'b000};
  assign access       = memtoreg_in || (memwrite_in != 4'b0000);
  assign unused_idata = ^{idata_in[31:15], idata_in[6:0]};

  // Alignment check: byte always fine, halfword needs even address, word needs 4-byte alignment.
  always_comb begin
    misaligned = 1'b0;
    case (funct3)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = ALUout_in[0];
      default:        misaligned = (ALUout_in[1:0] != 2'b00);
    endcase
  end

  // Load data: bring the addressed lane down to bit 0, then extend to the access width.
  always_comb begin
    rdata_shift = dmem_rdata >> shamt;
    case (funct3)
      3'b000:  load_data = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      3'b001:  load_data = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
      3'b100:  load_data = {24'h000000, rdata_shift[7:0]};
      3'b101:  load_data = {16'h0000, rdata_shift[15:0]};
      default: load_data = rdata_shift;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_cnt;

  assign timeout_hit = (state == S_WAIT) && (wait_cnt == 8'hFF);

  // Wait counter: restarts on entry to S_WAIT, counts every cycle spent waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 8'h00;
    end else if (state == S_IDLE && state_nxt == S_WAIT) begin
      wait_cnt <= 8'h00;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt + 8'h01;
    end
  end

  // Sticky timeout flag, only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_timeout <= 1'b0;
    end else if (timeout_hit) begin
      dmem_timeout <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (dmem_req && !dmem_ack) state_nxt = S_WAIT;
      S_WAIT:  if (dmem_ack || timeout_hit) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs; reset gates the request so an abandoned access drops at once.
  always_comb begin
    dmem_req = 1'b0;
    if (!rst) begin
      if (state == S_IDLE) dmem_req = access && !misaligned;
      else                 dmem_req = !timeout_hit;
    end
    dmem_we   = dmem_req ? memwrite_in : 4'b0000;
    mem_stall = dmem_req && !dmem_ack;
  end

  assign dmem_addr  = {ALUout_in[31:2], 2'b00};
  assign dmem_wdata = rv2_in << shamt;

  // MEM/WB register: advance when not stalled, otherwise insert a bubble holding the data fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwrite_out <= 1'b0;
      regin_out    <= 2'b00;
      memtoreg_out <= 1'b0;
      ALUout_out   <= 32'h0;
      ldata_out    <= 32'h0;
      immgen_out   <= 32'h0;
      PC_plus4_out <= 32'h0;
      rd_out       <= 5'h00;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= (state == S_IDLE) && access && misaligned;
      if (mem_stall || timeout_hit) begin
        regwrite_out <= 1'b0;
        memtoreg_out <= 1'b0;
      end else begin
        regwrite_out <= regwrite_in && !(access && misaligned);
        regin_out    <= regin_in;
        memtoreg_out <= memtoreg_in;
        ALUout_out   <= ALUout_in;
        immgen_out   <= immgen_in;
        PC_plus4_out <= PC_plus4_in;
        rd_out       <= idata_in[11:7];
        if (dmem_req && dmem_ack && memtoreg_in) ldata_out <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed corner cases plus randomized
// loads/stores/ALU ops against a byte-addressed reference memory model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        memtoreg_in, regwrite_in;
  logic [3:0]  memwrite_in;
  logic [31:0] ALUout_in, rv2_in, immgen_in, PC_plus4_in, idata_in;
  logic [1:0]  regin_in;
  logic        dmem_req;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        regwrite_out, memtoreg_out, mem_stall, misalign_err;
  logic [1:0]  regin_out;
  logic [31:0] ALUout_out, ldata_out, immgen_out, PC_plus4_out;
  logic [4:0]  rd_out;
`ifdef MEM_TIMEOUT_EN
  logic        dmem_timeout;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [0:15];
  logic [31:0] model_ldata;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .rst(rst),
    .memtoreg_in(memtoreg_in), .regwrite_in(regwrite_in), .memwrite_in(memwrite_in),
    .ALUout_in(ALUout_in), .rv2_in(rv2_in), .immgen_in(immgen_in), .regin_in(regin_in),
    .PC_plus4_in(PC_plus4_in), .idata_in(idata_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .regwrite_out(regwrite_out), .regin_out(regin_out), .memtoreg_out(memtoreg_out),
    .ALUout_out(ALUout_out), .ldata_out(ldata_out), .immgen_out(immgen_out),
    .PC_plus4_out(PC_plus4_out), .rd_out(rd_out), .mem_stall(mem_stall),
`ifdef MEM_TIMEOUT_EN
    .dmem_timeout(dmem_timeout),
`endif
    .misalign_err(misalign_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One instruction through the stage; memory acks after lat cycles of request.
  task automatic do_op(input logic ld, input logic [3:0] we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] rv2, input int lat);
    logic        acc, mis, exp_req, regw, done;
    int          sz, off, w, k;
    logic [31:0] word, val, exp_ld, exp_wd, imm, pc;
    logic [4:0]  rd;
    logic [1:0]  rin;
    logic [16:0] hi;
    acc = ld || (we != 4'b0000);
    case (f3)
      3'b000, 3'b100: sz = 1;
      3'b001, 3'b101: sz = 2;
      default:        sz = 4;
    endcase
    off     = int'(addr % 4);
    w       = int'((addr - 32'h100) / 4) % 16;
    mis     = acc && ((addr % sz) != 0);
    exp_req = acc && !mis;
    regw    = ld ? 1'b1 : (we != 0 ? 1'b0 : 1'($urandom_range(0, 1)));
    imm = $urandom; pc = $urandom; rd = 5'($urandom); rin = 2'($urandom); hi = 17'($urandom);
    exp_wd = rv2 << (8 * off);

    @(negedge clk);
    memtoreg_in = ld; regwrite_in = regw; memwrite_in = we; ALUout_in = addr;
    rv2_in = rv2; immgen_in = imm; regin_in = rin; PC_plus4_in = pc;
    idata_in = {hi, f3, rd, 7'h03};
    k = 0; done = 1'b0;
    while (!done) begin
      dmem_ack   = (k >= lat);
      dmem_rdata = mem[w];
      #1;
      chk("req", dmem_req, exp_req);
      chk("stall", mem_stall, exp_req && (k < lat));
      if (exp_req) begin
        chk("addr", dmem_addr, addr & 32'hFFFF_FFFC);
        chk("we", dmem_we, we);
        if (we != 0) chk("wdata", dmem_wdata, exp_wd);
      end
      if (exp_req && k < lat) begin
        @(posedge clk); #1;
        chk("bubble_rw", regwrite_out, 1'b0);
        chk("bubble_m2r", memtoreg_out, 1'b0);
        k++;
        if (k > 20) begin
          chk("ack_wait_bound", 32'(k), 32'(lat));
          done = 1'b1;
        end
        @(negedge clk);
      end else begin
        done = 1'b1;
      end
    end

    word = mem[w];
    val  = word >> (8 * off);
    case (f3)
      3'b000:  exp_ld = {{24{val[7]}}, val[7:0]};
      3'b001:  exp_ld = {{16{val[15]}}, val[15:0]};
      3'b100:  exp_ld = {24'h0, val[7:0]};
      3'b101:  exp_ld = {16'h0, val[15:0]};
      default: exp_ld = word;
    endcase
    if (exp_req && ld) model_ldata = exp_ld;
    if (exp_req && we != 0)
      for (int i = 0; i < 4; i++)
        if (we[i]) mem[w][8*i +: 8] = exp_wd[8*i +: 8];

    @(posedge clk); #1;
    chk("rw_out", regwrite_out, regw && !mis);
    chk("m2r_out", memtoreg_out, ld);
    chk("alu_out", ALUout_out, addr);
    chk("imm_out", immgen_out, imm);
    chk("pc_out", PC_plus4_out, pc);
    chk("regin_out", regin_out, rin);
    chk("rd_out", rd_out, rd);
    chk("ldata_out", ldata_out, model_ldata);
    chk("misalign_err", misalign_err, mis);
  endtask

  initial begin
    int kind, off, w;
    logic [2:0]  f3;
    logic [3:0]  we;
    logic [2:0]  ld_f3 [5];
    logic [2:0]  st_f3 [3];
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    st_f3 = '{3'b000, 3'b001, 3'b010};

    rst = 1'b1;
    memtoreg_in = 0; regwrite_in = 0; memwrite_in = 0; ALUout_in = 0; rv2_in = 0;
    immgen_in = 0; regin_in = 0; PC_plus4_in = 0; idata_in = 0; dmem_rdata = 0; dmem_ack = 0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    model_ldata = 32'h0;
    #12;
    chk("rst_rw", regwrite_out, 0);
    chk("rst_ldata", ldata_out, 0);
    chk("rst_alu", ALUout_out, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_merr", misalign_err, 0);
    @(negedge clk); rst = 1'b0;

    mem[0] = 32'hDEADBEEF;
    do_op(1'b1, 4'b0000, 3'b010, 32'h100, 32'h0, 0);
    chk("lw_deadbeef", ldata_out, 32'hDEADBEEF);
    mem[0] = 32'h80112233;
    do_op(1'b1, 4'b0000, 3'b000, 32'h103, 32'h0, 3);
    chk("lb_sext", ldata_out, 32'hFFFFFF80);
    do_op(1'b1, 4'b0000, 3'b100, 32'h103, 32'h0, 3);
    chk("lbu_zext", ldata_out, 32'h00000080);
    do_op(1'b0, 4'b0100, 3'b000, 32'h102, 32'h000000AB, 0);
    chk("sb_mem", mem[0], 32'h80AB2233);
    do_op(1'b1, 4'b0000, 3'b010, 32'h102, 32'h0, 0);
    do_op(1'b0, 4'b0000, 3'b011, 32'h105, 32'h0, 0);

    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 2);
      off  = $urandom_range(0, 3);
      w    = $urandom_range(0, 15);
      if (kind == 0) begin
        f3 = ld_f3[$urandom_range(0, 4)];
        do_op(1'b1, 4'b0000, f3, 32'h100 + 32'(w * 4 + off), 32'h0, $urandom_range(0, 4));
      end else if (kind == 1) begin
        f3 = st_f3[$urandom_range(0, 2)];
        we = (f3 == 3'b000) ? 4'(1 << off) : (f3 == 3'b001) ? 4'(3 << off) : 4'hF;
        do_op(1'b0, we, f3, 32'h100 + 32'(w * 4 + off), $urandom, $urandom_range(0, 4));
      end else begin
        do_op(1'b0, 4'b0000, 3'($urandom), 32'h100 + 32'(w * 4 + off), $urandom, 0);
      end
    end

    // Reset during an outstanding access, then a stray ack afterwards.
    @(negedge clk);
    memtoreg_in = 1; regwrite_in = 1; memwrite_in = 0; ALUout_in = 32'h104;
    idata_in = {17'h0, 3'b010, 5'd3, 7'h03}; dmem_ack = 0;
    @(posedge clk);
    @(negedge clk); #1;
    chk("wait_stall", mem_stall, 1'b1);
    rst = 1'b1; #1;
    chk("rstw_req", dmem_req, 0);
    chk("rstw_stall", mem_stall, 0);
    chk("rstw_rw", regwrite_out, 0);
    chk("rstw_ldata", ldata_out, 0);
    chk("rstw_alu", ALUout_out, 0);
    chk("rstw_rd", rd_out, 0);
    @(negedge clk);
    rst = 1'b0; memtoreg_in = 0; regwrite_in = 0; dmem_ack = 1; dmem_rdata = 32'h12345678; #1;
    chk("late_ack_req", dmem_req, 0);
    @(posedge clk); #1;
    chk("late_ack_ldata", ldata_out, 0);
    model_ldata = 32'h0;
    do_op(1'b1, 4'b0000, 3'b101, 32'h10A, 32'h0, 1);

`ifdef MEM_TIMEOUT_EN
    begin
      int ns;
      @(negedge clk);
      memtoreg_in = 1; regwrite_in = 1; memwrite_in = 0; ALUout_in = 32'h108;
      idata_in = {17'h0, 3'b010, 5'd4, 7'h03}; dmem_ack = 0;
      ns = 0;
      #1;
      while (mem_stall && ns < 400) begin
        ns++;
        @(posedge clk); @(negedge clk); #1;
      end
      chk("to_stall_cycles", 32'(ns), 32'd256);
      chk("to_req", dmem_req, 0);
      @(posedge clk); #1;
      chk("to_flag", dmem_timeout, 1);
      chk("to_bubble", regwrite_out, 0);
      @(negedge clk); memtoreg_in = 0; regwrite_in = 0;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
